// File: rtl/ps2_dev_pkg.sv
// Shared types for the multi-channel PS/2 device-side serialiser.
package ps2_dev_pkg;

    // Per-channel transmit FSM; START..PARITY are consecutive so the
    // frame walks forward by incrementing the state code.
    typedef enum logic [3:0] {
        IDLE, START, D0, D1, D2, D3, D4, D5, D6, D7, PARITY, STOP
    } ps2_tx_state_t;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_dev_tx_chan.sv
// One PS/2 transmit channel: byte FIFO, frame FSM and shifter.
// All frame progress happens on i_rise, the shared PS/2 clock rising tick.
module ps2_dev_tx_chan
    import ps2_dev_pkg::*;
#(
    parameter int FIFO_BITS = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rise,
    input  logic       i_phase,
    input  logic       i_inhibit,
    input  logic       i_wr,
    input  logic [7:0] i_din,
    output logic       o_ps2_clk,
    output logic       o_ps2_data,
    output logic       o_busy,
    output logic       o_overflow
);
    localparam int DEPTH = 2 ** FIFO_BITS;

    logic [7:0]           r_mem [DEPTH];
    logic [FIFO_BITS-1:0] r_wptr;
    logic [FIFO_BITS-1:0] r_rptr;
    logic [FIFO_BITS:0]   r_count;
    logic                 r_ovf;
    logic                 r_avail;
    ps2_tx_state_t        r_state;
    logic [7:0]           r_shift;
    logic                 r_par;
    logic                 r_data;
    logic                 r_busy;

    logic                 w_full;
    logic                 w_pop;
    logic                 w_wr_acc;
    logic                 w_abort;
    logic [FIFO_BITS:0]   w_count_nxt;
    ps2_tx_state_t        w_state_nxt;

    assign w_full      = (r_count == (FIFO_BITS+1)'(DEPTH));
    // Head is only released once its stop bit has gone out, so an aborted
    // frame can be resent from the same slot.
    assign w_pop       = i_rise && (r_state == STOP);
    assign w_wr_acc    = i_wr && (!w_full || w_pop);
    assign w_abort     = i_rise && i_inhibit && (r_state != IDLE) && (r_state != STOP);
    assign w_count_nxt = r_count + (FIFO_BITS+1)'(w_wr_acc) - (FIFO_BITS+1)'(w_pop);

    // Next frame state, shared by the FSM and the busy flag.
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = IDLE;
        end else if (i_rise) begin
            case (r_state)
                IDLE:    if (r_avail && !i_inhibit) w_state_nxt = START;
                STOP:    w_state_nxt = IDLE;
                default: w_state_nxt = ps2_tx_state_t'(r_state + 4'd1);
            endcase
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + FIFO_BITS'(1);
            if (w_pop)    r_rptr <= r_rptr + FIFO_BITS'(1);
            r_count <= w_count_nxt;
            if (i_wr && !w_wr_acc) r_ovf <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge i_clk) begin
        if (w_wr_acc) r_mem[r_wptr] <= i_din;
    end

    // Frame FSM: data changes only on the rising tick (clock high).
    // r_avail lags the count by a cycle so a fresh byte never starts on
    // the edge right after its write.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_data  <= 1'b1;
            r_busy  <= 1'b0;
            r_avail <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE) || (w_count_nxt != '0);
            r_avail <= (r_count != '0);
            if (w_abort) begin
                r_data <= 1'b1;
            end else if (i_rise) begin
                case (r_state)
                    IDLE: begin
                        if (w_state_nxt == START) begin
                            r_shift <= r_mem[r_rptr];
                            r_par   <= 1'b1;
                            r_data  <= 1'b0;
                        end
                    end
                    D7:           r_data <= r_par;
                    PARITY, STOP: r_data <= 1'b1;
                    default: begin
                        r_data  <= r_shift[0];
                        r_par   <= r_par ^ r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                    end
                endcase
            end
        end
    end

    assign o_ps2_clk  = i_phase || (r_state == IDLE);
    assign o_ps2_data = r_data;
    assign o_busy     = r_busy;
    assign o_overflow = r_ovf;

endmodule

// File: rtl/ps2_dev_tx.sv
// Multi-channel PS/2 device-side serialiser top: shared bit-clock divider
// and per-channel transmitters. Optional host-inhibit sensing is enabled by
// defining PS2_DEV_TX_INHIBIT_EN.
module ps2_dev_tx
    import ps2_dev_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int FIFO_BITS = 3,
    parameter int PS2DIV    = 20
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [NCH-1:0]   wr,
    input  logic [8*NCH-1:0] din,
    input  logic [NCH-1:0]   ps2_clk_in,
    output logic [NCH-1:0]   ps2_clk,
    output logic [NCH-1:0]   ps2_data,
    output logic [NCH-1:0]   busy,
    output logic [NCH-1:0]   overflow
);
    localparam int DIVW = (PS2DIV > 1) ? $clog2(PS2DIV) : 1;

    logic [DIVW-1:0] r_div;
    logic            r_phase;
    logic            w_tick;
    logic            w_rise;
    logic [NCH-1:0]  w_inhibit;

    assign w_tick = (r_div == DIVW'(PS2DIV - 1));
    assign w_rise = w_tick && !r_phase;

    // Shared half-period divider; one phase for every channel keeps them aligned.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_div   <= '0;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            r_div   <= '0;
            r_phase <= !r_phase;
        end else begin
            r_div   <= r_div + DIVW'(1);
        end
    end

`ifdef PS2_DEV_TX_INHIBIT_EN
    logic [NCH-1:0] r_sync1;
    logic [NCH-1:0] r_sync2;

    // Two-flop synchroniser on the sensed host clock lines (idle high).
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= ps2_clk_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_inhibit = ~r_sync2;
`else
    logic [NCH-1:0] w_unused_clk_in;
    assign w_unused_clk_in = ps2_clk_in;
    assign w_inhibit       = '0;
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        ps2_dev_tx_chan #(
            .FIFO_BITS (FIFO_BITS)
        ) u_chan (
            .i_clk      (clk_sys),
            .i_rst_n    (reset_n),
            .i_rise     (w_rise),
            .i_phase    (r_phase),
            .i_inhibit  (w_inhibit[c]),
            .i_wr       (wr[c]),
            .i_din      (din[8*c +: 8]),
            .o_ps2_clk  (ps2_clk[c]),
            .o_ps2_data (ps2_data[c]),
            .o_busy     (busy[c]),
            .o_overflow (overflow[c])
        );
    end

endmodule

// File: tb/tb_ps2_dev_tx.sv
// Bench for ps2_dev_tx: bytes written are queued as expected 11-bit frames;
// a line monitor rebuilds frames from falling ps2_clk edges and compares.
module tb_ps2_dev_tx;
    localparam int NCH       = 2;
    localparam int FIFO_BITS = 3;
    localparam int PS2DIV    = 4;

    logic             clk_sys = 1'b0;
    logic             reset_n;
    logic [NCH-1:0]   wr;
    logic [8*NCH-1:0] din;
    logic [NCH-1:0]   ps2_clk_in;
    logic [NCH-1:0]   ps2_clk;
    logic [NCH-1:0]   ps2_data;
    logic [NCH-1:0]   busy;
    logic [NCH-1:0]   overflow;

    ps2_dev_tx #(.NCH(NCH), .FIFO_BITS(FIFO_BITS), .PS2DIV(PS2DIV)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .wr         (wr),
        .din        (din),
        .ps2_clk_in (ps2_clk_in),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // start(0), data LSB first, odd parity, stop(1); bit 0 goes out first
    function automatic logic [10:0] mk_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    logic [10:0] exp_q [NCH][$];

    // line monitor state
    int          cyc = 0;
    logic [NCH-1:0] prev_clk = '1;
    int          nbits       [NCH];
    logic [10:0] sh          [NCH];
    int          frames_done [NCH];
    int          fall_total  [NCH];
    int          high_cnt    [NCH];
    int          aborts      [NCH];
    int          frame_start [NCH];
    int          end_fall    [NCH];
    int          gap         [NCH];

    initial begin
        for (int c = 0; c < NCH; c++) begin
            nbits[c] = 0; sh[c] = '0; frames_done[c] = 0; fall_total[c] = 0;
            high_cnt[c] = 0; aborts[c] = 0; frame_start[c] = 0; end_fall[c] = 0; gap[c] = 0;
        end
    end

    always @(negedge clk_sys) begin
        cyc++;
        for (int c = 0; c < NCH; c++) begin
            if (prev_clk[c] && !ps2_clk[c]) begin
                if (nbits[c] == 0) begin
                    frame_start[c] = cyc;
                    gap[c] = cyc - end_fall[c];
                end
                sh[c] = {ps2_data[c], sh[c][10:1]};
                nbits[c]++;
                fall_total[c]++;
                high_cnt[c] = 0;
                if (nbits[c] == 11) begin
                    nbits[c] = 0;
                    end_fall[c] = cyc;
                    frames_done[c]++;
                    if (exp_q[c].size() == 0)
                        chk($sformatf("ch%0d_extra_frame", c), exp_q[c].size(), 1);
                    else
                        chk($sformatf("ch%0d_frame", c), sh[c], exp_q[c].pop_front());
                end
            end else if (ps2_clk[c]) begin
                high_cnt[c]++;
                if (high_cnt[c] > PS2DIV + 1 && nbits[c] != 0) begin
                    aborts[c]++;
                    nbits[c] = 0;
                end
            end else begin
                high_cnt[c] = 0;
            end
        end
        prev_clk = ps2_clk;
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic put(input int c, input logic [7:0] b, input bit expect_out);
        wr[c] = 1'b1;
        din[8*c +: 8] = b;
        if (expect_out) exp_q[c].push_back(mk_frame(b));
        step();
        wr = '0;
    endtask

    task automatic wait_frames(input string tag, input int c, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (frames_done[c] >= target) break;
            step();
        end
        chk(tag, frames_done[c], target);
    endtask

    task automatic wait_bits(input string tag, input int c, input int n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (nbits[c] == n) break;
            step();
        end
        if (i == budget) chk(tag, nbits[c], n);
    endtask

    int base, f0, a0;

    initial begin
        reset_n = 1'b0; wr = '0; din = '0; ps2_clk_in = '1;
        repeat (3) step();
        chk("rst_clk", ps2_clk, 2'b11);
        chk("rst_data", ps2_data, 2'b11);
        chk("rst_busy", busy, 2'b00);
        chk("rst_ovf", overflow, 2'b00);
        reset_n = 1'b1;
        repeat (5) step();

        // 1: single byte on ch0
        put(0, 8'h1C, 1);
        chk("t1_busy_hi", busy[0], 1'b1);
        wait_frames("t1_done", 0, 1, 300);
        repeat (PS2DIV) step();
        chk("t1_busy_lo", busy[0], 1'b0);

        // 2: back-to-back on ch1, ch0 must stay quiet
        f0 = fall_total[0];
        put(1, 8'h00, 1);
        put(1, 8'hFF, 1);
        wait_frames("t2_done", 1, 2, 400);
        chk("t2_gap", gap[1], 4 * PS2DIV);
        chk("t2_ch0_quiet", fall_total[0], f0);

        // 3: overflow on ch1, then a write landing on the pop of a full FIFO
        base = frames_done[1];
        for (int i = 0; i < 8; i++) put(1, 8'(i + 1), 1);
        chk("t3_ovf_pre", overflow[1], 1'b0);
        put(1, 8'hEE, 0);
        chk("t3_ovf_set", overflow[1], 1'b1);
        wait_frames("t3_first", 1, base + 1, 300);
        repeat (PS2DIV - 2) step();
        put(1, 8'h5A, 1);
        wait_frames("t3_done", 1, base + 9, 1500);
        chk("t3_ovf_sticky", overflow[1], 1'b1);

        // 4: reset during D3 with a byte queued behind
        put(0, 8'h33, 1);
        put(0, 8'h44, 1);
        wait_bits("t4_reach_d3", 0, 5, 300);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        exp_q[0].delete();
        exp_q[1].delete();
        @(negedge clk_sys);
        chk("t4_clk", ps2_clk, 2'b11);
        chk("t4_data", ps2_data, 2'b11);
        chk("t4_busy", busy, 2'b00);
        chk("t4_ovf", overflow, 2'b00);
        step();
        f0 = fall_total[0];
        repeat (400) step();
        chk("t4_no_frames", fall_total[0], f0);

        // 5: host inhibit during D5 of 8'hAA
        a0 = aborts[0];
        base = frames_done[0];
        put(0, 8'hAA, 1);
        wait_bits("t5_reach_d5", 0, 7, 300);
        ps2_clk_in[0] = 1'b0;
        repeat (8 * PS2DIV) step();
        ps2_clk_in[0] = 1'b1;
        wait_frames("t5_done", 0, base + 1, 400);
`ifdef PS2_DEV_TX_INHIBIT_EN
        chk("t5_aborts", aborts[0] - a0, 1);
`else
        chk("t5_aborts", aborts[0] - a0, 0);
`endif

        // 6: both channels in the same cycle
        repeat (20) step();
        base = frames_done[0];
        f0 = frames_done[1];
        wr = 2'b11;
        din = {8'hF0, 8'h12};
        exp_q[0].push_back(mk_frame(8'h12));
        exp_q[1].push_back(mk_frame(8'hF0));
        step();
        wr = '0;
        wait_frames("t6_ch0", 0, base + 1, 300);
        wait_frames("t6_ch1", 1, f0 + 1, 300);
        chk("t6_aligned", frame_start[0], frame_start[1]);

        repeat (20) step();
        chk("q0_empty", exp_q[0].size(), 0);
        chk("q1_empty", exp_q[1].size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
